cycle_timer: RTL and testbench
==============================

# cycle_timer

Machine-cycle phase generator for the memory/ALU section. It divides the system clock into a ten-phase machine cycle and drives the active-low phase strobes `tn[10:1]` consumed by the RAM stage: page-register load on tn[4] fall, write-enable clear on tn[3] fall, nibble select clear on tn[5] fall, address latch on tn[8] fall, and write/select set on tn[10] rise. Cycles run continuously, single-step, or stretch in the memory-wait phase.

## Interface
Parameters:
- `PHASE_DIV`, 4: sys_clk cycles per phase; legal range ≥1.
- `WAIT_PHASE`, 6: the phase (1..10) that `mem_wait` may stretch.

Ports:
- `sys_clk`  in  1  system clock; all state updates on its rising edge.
- `resetn`  in  1  reset; asynchronous, active-low.
- `run`  in  1  level; continuous cycling while high.
- `step`  in  1  one-clk pulse; requests exactly one cycle while idle.
- `mem_wait`  in  1  level; holds WAIT_PHASE at its final clock while high.
- `tn`  out  [10:1]  phase strobes, active-low; only tn[k] is low during phase k.
- `phase`  out  4  current phase 1..10; 0 when idle.
- `busy`  out  1  high whenever phase ≠ 0.
- `cycle_strobe`  out  1  high for the first clk of phase 1.
- `cycle_done`  out  1  high for the last clk of phase 10.
- `cyc_count`  out  16  completed-cycle counter.

## Operation
- Reset values: tn = 10'h3FF, phase = 0, busy = 0, cycle_strobe = 0, cycle_done = 0, cyc_count = 0, state IDLE, div = 0, step_pend = 0.
- States:
  - IDLE: leave when `run | step` is sampled high. Go to PHASE with phase = 1 and div = 0.
  - PHASE: div counts 0..PHASE_DIV-1. At terminal div, advance phase and clear div, except in the two cases below.
  - WAIT: entered when phase == WAIT_PHASE, div is terminal, and mem_wait = 1. Hold phase and div; tn[WAIT_PHASE] stays low. Advance on the first edge that samples mem_wait = 0.
- End of phase 10 (terminal div):
  - cyc_count increments; it wraps from 16'hFFFF to 0.
  - If the cycle was a step cycle, return to IDLE.
  - Otherwise, if run = 1, go directly to phase 1 with no gap; if run = 0, go to IDLE.
- step is honoured only in IDLE and is ignored while busy. A step cycle runs exactly one cycle even if run rises during it. If run is still high at the end of that cycle, the next cycle starts from IDLE on the following edge.
- Simultaneous run and step in IDLE: run wins and the cycle is not a step cycle.
- run falling mid-cycle never truncates the cycle; phases 1..10 always complete.
- Reset mid-cycle: all outputs return to reset values immediately (asynchronously), and tn goes all-high.
- tn, phase, busy, cycle_strobe and cycle_done are all registered, with no combinational path from inputs. Exactly one tn bit is low while busy; none is low while idle.
- mem_wait is ignored outside the final clock of WAIT_PHASE.

## Timing
- Start latency: run or step sampled at edge N gives phase = 1, tn[1] = 0, busy = 1 and cycle_strobe = 1 after edge N.
- Unstretched cycle = 10·PHASE_DIV clocks. A mem_wait held for W sampled clocks adds exactly W clocks.
- Back-to-back cycles: the last clk of phase 10 is immediately followed by the first clk of phase 1, with cycle_done and cycle_strobe in adjacent clocks.
- cyc_count updates on the same edge on which cycle_done deasserts.
- tn edges coincide with phase changes, so adjacent strobes never overlap and no strobe glitches.

## Structure
- Shared package `cycle_pkg`:
  - phase constants `PH_T1..PH_T10`;
  - state enum `{CT_IDLE, CT_PHASE, CT_WAIT}`;
  - `TN_IDLE = 10'h3FF`.
- One natural sub-module: `phase_div`, a terminal-count divider with a hold input.
- The FSM, phase register, tn decode register and cycle counter live in `cycle_timer`.

## Test plan
All scenarios use PHASE_DIV = 4 and WAIT_PHASE = 6.
- Single step pulse at clk 0 → busy for clks 0..39; tn[k] low on clks 4(k-1)..4k-1; cycle_done at clk 39; cyc_count = 1; idle at clk 40.
- step with mem_wait high for 5 clocks from clk 23 → phase 6 spans clks 20..28; cycle_done at clk 44; total 45 busy clocks.
- run held high for 3 cycles, then low → cycle_strobe at clks 0, 40, 80 with no idle gap; cyc_count = 3; idle at clk 120.
- run dropped at clk 18 (phase 5) → cycle completes to clk 39, then idle; a step pulsed at clk 10 is ignored (cyc_count = 1).
- resetn low at clk 26 (phase 7) → tn = 3FF, phase = 0, cyc_count = 0 asynchronously; restart timing after release matches the first scenario.
- Preload cyc_count to 16'hFFFF by forcing, then step → cyc_count = 0 after cycle_done.

Source files
------------

// File: rtl/cycle_pkg.sv
// Shared definitions for the machine-cycle phase generator: phase numbers,
// controller states and the idle strobe pattern.
package cycle_pkg;

  localparam logic [3:0] PH_NONE = 4'd0;
  localparam logic [3:0] PH_T1   = 4'd1;
  localparam logic [3:0] PH_T2   = 4'd2;
  localparam logic [3:0] PH_T3   = 4'd3;
  localparam logic [3:0] PH_T4   = 4'd4;
  localparam logic [3:0] PH_T5   = 4'd5;
  localparam logic [3:0] PH_T6   = 4'd6;
  localparam logic [3:0] PH_T7   = 4'd7;
  localparam logic [3:0] PH_T8   = 4'd8;
  localparam logic [3:0] PH_T9   = 4'd9;
  localparam logic [3:0] PH_T10  = 4'd10;

  localparam logic [10:1] TN_IDLE = 10'h3FF;

  typedef enum logic [1:0] {CT_IDLE, CT_PHASE, CT_WAIT} ct_state_e;

  // Active-low one-cold strobe pattern for a phase; all high outside 1..10.
  function automatic logic [10:1] tn_decode(input logic [3:0] ph);
    logic [10:1] v;
    v = TN_IDLE;
    for (int k = 1; k <= 10; k++) begin
      if (ph == 4'(k)) v[k] = 1'b0;
    end
    return v;
  endfunction

endpackage

// File: rtl/cycle_timer_phase_div.sv
// Terminal-count divider that sets the length of one phase; it can freeze on
// its terminal count to stretch the memory-wait phase.
module phase_div #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic hold,
  output logic tc,
  output logic tc_next
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] MAX = W'(DIV - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (!en)
      cnt_d = '0;
    else if (!hold)
      cnt_d = (cnt_q == MAX) ? '0 : cnt_q + 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign tc      = (cnt_q == MAX);
  assign tc_next = (cnt_d == MAX);

endmodule

// File: rtl/cycle_timer.sv
// Ten-phase machine-cycle generator driving the active-low RAM strobes tn[10:1];
// supports continuous run, single step and a memory-wait stretch.
module cycle_timer
  import cycle_pkg::*;
#(
  parameter int PHASE_DIV  = 4,
  parameter int WAIT_PHASE = 6
) (
  input  logic        sys_clk,
  input  logic        resetn,
  input  logic        run,
  input  logic        step,
  input  logic        mem_wait,
  output logic [10:1] tn,
  output logic [3:0]  phase,
  output logic        busy,
  output logic        cycle_strobe,
  output logic        cycle_done,
  output logic [15:0] cyc_count
);

  ct_state_e   state_q, state_d;
  logic [3:0]  phase_q, phase_d;
  logic        step_pend_q, step_pend_d;
  logic [15:0] cyc_q;
  logic [10:1] tn_q;
  logic        busy_q, strobe_q, done_q;
  logic        start, cycle_end;
  logic        div_en, div_hold, div_tc, div_tc_next;
  logic        at_wait_phase;

  assign at_wait_phase = (phase_q == 4'(WAIT_PHASE));
  assign div_en        = (state_q != CT_IDLE);
  assign div_hold      = div_en && at_wait_phase && div_tc && mem_wait;

  phase_div #(.DIV(PHASE_DIV)) u_div (
    .clk     (sys_clk),
    .rst_n   (resetn),
    .en      (div_en),
    .hold    (div_hold),
    .tc      (div_tc),
    .tc_next (div_tc_next)
  );

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    step_pend_d = step_pend_q;
    start       = 1'b0;
    cycle_end   = 1'b0;
    case (state_q)
      CT_IDLE: begin
        if (run || step) begin
          state_d     = CT_PHASE;
          phase_d     = PH_T1;
          step_pend_d = !run;   // run wins over a simultaneous step
          start       = 1'b1;
        end
      end
      CT_PHASE, CT_WAIT: begin
        if (div_tc) begin
          if (at_wait_phase && mem_wait) begin
            state_d = CT_WAIT;
          end else if (phase_q == PH_T10) begin
            cycle_end   = 1'b1;
            step_pend_d = 1'b0;
            if (step_pend_q || !run) begin
              state_d = CT_IDLE;
              phase_d = PH_NONE;
            end else begin
              state_d = CT_PHASE;
              phase_d = PH_T1;
              start   = 1'b1;
            end
          end else begin
            state_d = CT_PHASE;
            phase_d = phase_q + 4'd1;
          end
        end
      end
      default: begin
        state_d = CT_IDLE;
        phase_d = PH_NONE;
      end
    endcase
  end

  // Outputs are registered from next-state values so strobe edges align with phase changes.
  always_ff @(posedge sys_clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= CT_IDLE;
      phase_q     <= PH_NONE;
      step_pend_q <= 1'b0;
      cyc_q       <= '0;
      tn_q        <= TN_IDLE;
      busy_q      <= 1'b0;
      strobe_q    <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      step_pend_q <= step_pend_d;
      tn_q        <= tn_decode(phase_d);
      busy_q      <= (phase_d != PH_NONE);
      strobe_q    <= start;
      done_q      <= (phase_d == PH_T10) && div_tc_next && (state_d == CT_PHASE);
      if (cycle_end) cyc_q <= cyc_q + 16'd1;
    end
  end

  assign tn           = tn_q;
  assign phase        = phase_q;
  assign busy         = busy_q;
  assign cycle_strobe = strobe_q;
  assign cycle_done   = done_q;
  assign cyc_count    = cyc_q;

endmodule

// File: tb/tb_cycle_timer.sv
// Randomized and directed bench for cycle_timer against a cycle-position model
// that tracks elapsed clocks within the current machine cycle.
module tb_cycle_timer;

  localparam int DIV = 4;
  localparam int WP  = 6;
  localparam int CYC = 10 * DIV;

  logic        sys_clk;
  logic        resetn;
  logic        run, step, mem_wait;
  logic [10:1] tn;
  logic [3:0]  phase;
  logic        busy, cycle_strobe, cycle_done;
  logic [15:0] cyc_count;

  int checks = 0;
  int errors = 0;

  // Reference model: position t within the unstretched cycle.
  bit          m_active, m_step, m_start;
  int          m_t;
  logic [15:0] m_count;

  cycle_timer #(.PHASE_DIV(DIV), .WAIT_PHASE(WP)) dut (
    .sys_clk      (sys_clk),
    .resetn       (resetn),
    .run          (run),
    .step         (step),
    .mem_wait     (mem_wait),
    .tn           (tn),
    .phase        (phase),
    .busy         (busy),
    .cycle_strobe (cycle_strobe),
    .cycle_done   (cycle_done),
    .cyc_count    (cyc_count)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic void model_reset();
    m_active = 0; m_step = 0; m_start = 0; m_t = 0; m_count = 16'd0;
  endfunction

  function automatic void model_edge(input bit r, input bit s, input bit w);
    m_start = 0;
    if (!m_active) begin
      if (r || s) begin
        m_active = 1; m_t = 0; m_step = !r; m_start = 1;
      end
    end else if (m_t == WP * DIV - 1 && w) begin
      // stretched: position frozen
    end else if (m_t == CYC - 1) begin
      m_count = m_count + 16'd1;
      if (m_step || !r) m_active = 0;
      else begin
        m_t = 0; m_step = 0; m_start = 1;
      end
    end else begin
      m_t++;
    end
  endfunction

  task automatic check_all(input string tag);
    int          ep;
    logic [9:0]  etn;
    ep  = m_active ? (m_t / DIV + 1) : 0;
    etn = m_active ? ~(10'd1 << (ep - 1)) : 10'h3FF;
    check({tag, ".phase"}, 32'(phase), 32'(ep));
    check({tag, ".tn"}, 32'(tn), 32'(etn));
    check({tag, ".busy"}, 32'(busy), 32'(m_active));
    check({tag, ".strobe"}, 32'(cycle_strobe), 32'(m_start));
    check({tag, ".done"}, 32'(cycle_done), 32'(m_active && m_t == CYC - 1));
    check({tag, ".count"}, 32'(cyc_count), 32'(m_count));
  endtask

  // Hold inputs for the current clock, advance one edge, compare on the falling edge.
  task automatic tick(input string tag, input bit r, input bit s, input bit w);
    run = r; step = s; mem_wait = w;
    @(posedge sys_clk);
    model_edge(r, s, w);
    @(negedge sys_clk);
    check_all(tag);
  endtask

  task automatic idle_ticks(input string tag, input int n);
    for (int i = 0; i < n; i++) tick(tag, 0, 0, 0);
  endtask

  initial begin
    int   done_at, strobes, busy_clks;
    bit   r;
    logic [15:0] base;

    resetn = 1'b0; run = 0; step = 0; mem_wait = 0;
    model_reset();
    repeat (2) @(negedge sys_clk);
    check_all("reset");
    resetn = 1'b1;
    idle_ticks("idle", 3);

    // Single step: busy clks 0..39, done at 39, idle at 40.
    tick("s1", 0, 1, 0);
    check("s1_tn1_low", 32'(tn), 32'h3FE);
    done_at = -1;
    for (int c = 1; c < 40; c++) begin
      tick("s1", 0, 0, 0);
      if (cycle_done && done_at < 0) done_at = c;
    end
    check("s1_done_clk", 32'(done_at), 32'd39);
    tick("s1", 0, 0, 0);
    check("s1_idle40", 32'(busy), 32'd0);
    check("s1_count", 32'(cyc_count), 32'd1);
    idle_ticks("s1", 2);

    // Step with mem_wait high for clocks 23..27: 45 busy clocks, done at 44.
    tick("s2", 0, 1, 0);
    busy_clks = 1; done_at = -1;
    for (int c = 0; c < 48; c++) begin
      tick("s2", 0, 0, (c >= 23 && c <= 27));
      if (busy) busy_clks++;
      if (cycle_done && done_at < 0) done_at = c + 1;
    end
    check("s2_busy_clks", 32'(busy_clks), 32'd45);
    check("s2_done_clk", 32'(done_at), 32'd44);

    // Run for three back-to-back cycles, then drop.
    base = cyc_count;
    tick("s3", 1, 0, 0);
    strobes = 1;
    for (int c = 0; c < 120; c++) begin
      tick("s3", (c < 100), 0, 0);
      if (cycle_strobe) strobes++;
    end
    check("s3_strobes", 32'(strobes), 32'd3);
    check("s3_idle120", 32'(busy), 32'd0);
    check("s3_count", 32'(cyc_count - base), 32'd3);
    idle_ticks("s3", 2);

    // Run dropped in phase 5, step at clk 10 ignored.
    base = cyc_count;
    tick("s4", 1, 0, 0);
    for (int c = 0; c < 45; c++) tick("s4", (c < 18), (c == 10), 0);
    check("s4_count", 32'(cyc_count - base), 32'd1);
    check("s4_idle", 32'(busy), 32'd0);

    // Asynchronous reset in phase 7, then restart.
    tick("s5", 0, 1, 0);
    for (int c = 0; c < 26; c++) tick("s5", 0, 0, 0);
    check("s5_ph7", 32'(phase), 32'd7);
    #2 resetn = 1'b0;
    model_reset();
    #1;
    check("s5_async_tn", 32'(tn), 32'h3FF);
    check("s5_async_phase", 32'(phase), 32'd0);
    check("s5_async_busy", 32'(busy), 32'd0);
    check("s5_async_count", 32'(cyc_count), 32'd0);
    @(negedge sys_clk);
    check_all("s5_rst");
    resetn = 1'b1;
    tick("s5r", 0, 1, 0);
    done_at = -1;
    for (int c = 1; c < 41; c++) begin
      tick("s5r", 0, 0, 0);
      if (cycle_done && done_at < 0) done_at = c;
    end
    check("s5_restart_done", 32'(done_at), 32'd39);

    // Counter wrap from FFFF.
    force dut.cyc_q = 16'hFFFF;
    @(posedge sys_clk);
    @(negedge sys_clk);
    release dut.cyc_q;
    m_count = 16'hFFFF;
    check("s6_preload", 32'(cyc_count), 32'hFFFF);
    tick("s6", 0, 1, 0);
    idle_ticks("s6", 41);
    check("s6_wrap", 32'(cyc_count), 32'd0);

    // Randomized run/step/mem_wait traffic.
    r = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 24) == 0) r = ~r;
      tick("rnd", r, ($urandom_range(0, 15) == 0), ($urandom_range(0, 2) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
